// File: rtl/pipe_stage_reg_pkg.sv
// ============================================================================
// Module   : pipe_stage_reg_pkg
// Purpose  : Shared pipeline constants and types for the stage register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PIPE_STAGE_REG_DEFS
`define PIPE_STAGE_REG_DEFS
`define WORD   32
`define NOP    32'h0000_0013
`define IFID_W (2*`WORD)
`endif

package pipe_stage_reg_pkg;

    localparam int unsigned OCC_W = 2;

    typedef struct packed {
        logic load;
        logic clear;
    } slot_ctrl_t;

    function automatic logic [OCC_W-1:0] occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module   : pipe_slot
// Purpose  : One valid+data register with load, clear and flush controls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  slot_ctrl_t       ctrl,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Load wins over clear so a simultaneous drain-and-refill keeps the slot full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else if (ctrl.load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ctrl.clear) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register with hold, flush and skid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             in_xfer;
    logic             out_xfer;
    logic             skid_valid;
    slot_ctrl_t       main_ctrl;
    logic [WIDTH-1:0] main_src;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready & ~hold;
    assign occupancy = occ_count(out_valid, skid_valid);

    pipe_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ctrl      (main_ctrl),
        .load_data (main_src),
        .valid     (out_valid),
        .data      (out_data)
    );

    generate
        if (SKID) begin : g_skid
            logic             main_free;
            logic [WIDTH-1:0] skid_data;
            slot_ctrl_t       skid_ctrl;

            // in_ready comes straight from a flop: no path from out_ready/hold.
            assign in_ready = ~skid_valid;

            always_comb begin
                main_free       = ~out_valid | out_xfer;
                main_ctrl.load  = main_free & (skid_valid | in_xfer);
                main_ctrl.clear = out_xfer;
                main_src        = skid_valid ? skid_data : in_data;
                skid_ctrl.load  = in_xfer & ~main_free;
                skid_ctrl.clear = main_free;
            end

            pipe_slot #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .ctrl      (skid_ctrl),
                .load_data (in_data),
                .valid     (skid_valid),
                .data      (skid_data)
            );
        end else begin : g_no_skid
            assign in_ready   = ~out_valid | (out_ready & ~hold);
            assign skid_valid = 1'b0;

            always_comb begin
                main_ctrl.load  = in_xfer;
                main_ctrl.clear = out_xfer;
                main_src        = in_data;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed and random checks of pipe_stage_reg (SKID=1 and SKID=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst;
    // SKID=1 instance
    logic       flush, hold, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    // SKID=0 instance
    logic       flush_0, hold_0, in_valid_0, out_ready_0;
    logic [7:0] in_data_0;
    logic       in_ready_0, out_valid_0;
    logic [7:0] out_data_0;
    logic [1:0] occupancy_0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(8), .RESET_VALUE(8'h00), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.WIDTH(8), .RESET_VALUE(8'h00), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush_0), .hold(hold_0),
        .in_valid(in_valid_0), .in_ready(in_ready_0), .in_data(in_data_0),
        .out_valid(out_valid_0), .out_ready(out_ready_0), .out_data(out_data_0),
        .occupancy(occupancy_0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [7:0] od,
                             input logic [1:0] occ, input logic ir);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".out_data"},  {24'd0, out_data},  {24'd0, od});
        chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream must keep in_data stable while stalled.
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;
    always @(posedge clk) begin
        if (rst && stall_prev && in_valid)
            chk("protocol.in_data_stable", {24'd0, in_data}, {24'd0, data_prev});
        stall_prev <= in_valid & ~in_ready;
        data_prev  <= in_data;
    end

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    logic [7:0] d1, d0;
    logic       rv, rr, rh, xin1, xout1, xin0, xout0;

    initial begin
        rst = 1'b0;
        flush = 0; hold = 0; in_valid = 0; out_ready = 0; in_data = 8'h00;
        flush_0 = 0; hold_0 = 0; in_valid_0 = 0; out_ready_0 = 0; in_data_0 = 8'h00;
        #1;
        chk_state("reset", 1'b0, 8'h00, 2'd0, 1'b1);
        #11 rst = 1'b1;

        // Fill to occupancy 2, then assert reset mid-cycle
        in_valid = 1; in_data = 8'h11; out_ready = 0;
        step(); chk_state("fill1", 1'b1, 8'h11, 2'd1, 1'b1);
        in_data = 8'h22;
        step(); chk_state("fill2", 1'b1, 8'h11, 2'd2, 1'b0);
        in_valid = 0;
        #2 rst = 1'b0;
        #1 chk_state("async_rst", 1'b0, 8'h00, 2'd0, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back flow with 1-cycle latency
        in_valid = 1; in_data = 8'h01; out_ready = 1;
        step(); chk_state("flow1", 1'b1, 8'h01, 2'd1, 1'b1);
        in_data = 8'h02;
        step(); chk_state("flow2", 1'b1, 8'h02, 2'd1, 1'b1);
        in_data = 8'h03;
        step(); chk_state("flow3", 1'b1, 8'h03, 2'd1, 1'b1);
        in_valid = 0;
        step(); chk_state("flow_drain", 1'b0, 8'h03, 2'd0, 1'b1);

        // Backpressure into the skid entry
        out_ready = 0; in_valid = 1; in_data = 8'h0A;
        step(); chk_state("bp_a", 1'b1, 8'h0A, 2'd1, 1'b1);
        in_data = 8'h0B;
        step(); chk_state("bp_b", 1'b1, 8'h0A, 2'd2, 1'b0);
        in_data = 8'h0C;
        step(); chk_state("bp_stall", 1'b1, 8'h0A, 2'd2, 1'b0);
        out_ready = 1;
        step(); chk_state("bp_rel1", 1'b1, 8'h0B, 2'd1, 1'b1);
        step(); chk_state("bp_rel2", 1'b1, 8'h0C, 2'd1, 1'b1);
        in_valid = 0;
        step(); chk_state("bp_done", 1'b0, 8'h0C, 2'd0, 1'b1);

        // Hold freezes the output side
        in_valid = 1; in_data = 8'h55;
        step(); chk_state("hold_load", 1'b1, 8'h55, 2'd1, 1'b1);
        in_valid = 0; hold = 1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_state("hold", 1'b1, 8'h55, 2'd1, 1'b1);
        end
        hold = 0;
        step(); chk_state("hold_release", 1'b0, 8'h55, 2'd0, 1'b1);

        // Hold on an empty stage still fills the bubble, skid absorbs one more
        hold = 1; in_valid = 1; in_data = 8'h66;
        step(); chk_state("hold_bubble", 1'b1, 8'h66, 2'd1, 1'b1);
        in_data = 8'h67;
        step(); chk_state("hold_skid", 1'b1, 8'h66, 2'd2, 1'b0);

        // Flush with occupancy 2 and a pending input
        in_data = 8'h77; flush = 1;
        step(); chk_state("flush", 1'b0, 8'h00, 2'd0, 1'b1);
        flush = 0; in_valid = 0;
        step(); chk_state("flush_after", 1'b0, 8'h00, 2'd0, 1'b1);

        // Flush and hold together, input transfer in the flush cycle is dropped
        in_valid = 1; in_data = 8'h88;
        step(); chk_state("fh_load", 1'b1, 8'h88, 2'd1, 1'b1);
        in_data = 8'h99; flush = 1;
        step(); chk_state("fh_flush", 1'b0, 8'h00, 2'd0, 1'b1);
        flush = 0; hold = 0; in_valid = 0;
        step(); chk_state("fh_after", 1'b0, 8'h00, 2'd0, 1'b1);

        // Same random traffic into both variants, each against a FIFO model
        d1 = 8'h00; d0 = 8'h80;
        for (int i = 0; i < 1000; i++) begin
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            in_valid   = rv; out_ready   = rr; hold   = rh; in_data   = d1;
            in_valid_0 = rv; out_ready_0 = rr; hold_0 = rh; in_data_0 = d0;
            #1;
            chk("rnd0.in_ready", {31'd0, in_ready_0},
                {31'd0, (q0.size() == 0) || (rr && !rh)});
            chk("rnd1.in_ready", {31'd0, in_ready}, {31'd0, q1.size() < 2});
            xin1  = in_valid & in_ready;
            xout1 = out_valid & out_ready & ~hold;
            xin0  = in_valid_0 & in_ready_0;
            xout0 = out_valid_0 & out_ready_0 & ~hold_0;
            @(posedge clk);
            if (xout1 && q1.size() > 0) void'(q1.pop_front());
            if (xin1) begin q1.push_back(d1); d1 = d1 + 8'd1; end
            if (xout0 && q0.size() > 0) void'(q0.pop_front());
            if (xin0) begin q0.push_back(d0); d0 = d0 + 8'd1; end
            #1;
            chk("rnd1.occupancy", {30'd0, occupancy}, q1.size());
            chk("rnd1.out_valid", {31'd0, out_valid}, {31'd0, q1.size() != 0});
            if (q1.size() != 0) chk("rnd1.out_data", {24'd0, out_data}, {24'd0, q1[0]});
            chk("rnd0.occupancy", {30'd0, occupancy_0}, q0.size());
            chk("rnd0.occ_le1", {31'd0, occupancy_0 <= 2'd1}, 32'd1);
            chk("rnd0.out_valid", {31'd0, out_valid_0}, {31'd0, q0.size() != 0});
            if (q0.size() != 0) chk("rnd0.out_data", {24'd0, out_data_0}, {24'd0, q0[0]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
